// File: rtl/conv_fprop3_mul_arbiter.sv
// conv_fprop3_mul_arbiter
// Shares one pipelined 31ns x 32s multiplier between NUM_REQ requesters.
// Requesters are served round-robin. Operands are registered, multiplied in a
// ce-gated stage, and returned with the index of the requester that sent them.
// A downstream stall (res_valid & ~res_ready) freezes the whole pipe.
// Build option: define MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer). Ports, latency and stall behaviour are the same
// in both builds.
module conv_fprop3_mul_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 31,
    parameter int B_WIDTH   = 32,
    parameter int P_WIDTH   = 58,
    parameter int TAG_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [TAG_WIDTH-1:0]         res_tag,
    output logic [P_WIDTH-1:0]           res_p,
    output logic                         busy
);

    localparam int FULL_W = A_WIDTH + B_WIDTH + 1;

    // Keep the low P_WIDTH bits of the full-precision product.
    function automatic logic signed [P_WIDTH-1:0] trunc_prod(input logic signed [FULL_W-1:0] full);
        return full[P_WIDTH-1:0];
    endfunction

    logic                        ce;
    logic                        xfer;
    logic                        gnt_vld;
    logic [TAG_WIDTH-1:0]        gnt_idx;
    logic [TAG_WIDTH-1:0]        base;
    logic [A_WIDTH-1:0]          a_sel;
    logic signed [B_WIDTH-1:0]   b_sel;

    // Stage 1: input registers
    logic [A_WIDTH-1:0]          a_p1_q;
    logic signed [B_WIDTH-1:0]   b_p1_q;
    logic [TAG_WIDTH-1:0]        tag_p1_q;
    logic                        vld_p1_q;

    // Stage 2: multiplier register
    logic signed [FULL_W-1:0]    prod_full;
    logic signed [P_WIDTH-1:0]   p_p2_q;
    logic [TAG_WIDTH-1:0]        tag_p2_q;
    logic                        vld_p2_q;

    // A held result blocks every stage; the pipe only advances on ce.
    assign ce = ~(vld_p2_q & ~res_ready);

`ifdef MUL_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [TAG_WIDTH-1:0] rr_ptr_q;
    logic [TAG_WIDTH-1:0] rr_ptr_d;

    assign base = rr_ptr_q;

    // Next pointer: one past the granted requester, wrapping at NUM_REQ-1.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (gnt_idx == TAG_WIDTH'(NUM_REQ - 1)) rr_ptr_d = '0;
            else                                    rr_ptr_d = gnt_idx + TAG_WIDTH'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Search for the first valid requester starting at base, modulo NUM_REQ.
    always_comb begin
        int                   idx;
        logic [TAG_WIDTH-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(base) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = TAG_WIDTH'(idx);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign req_ready = (reset && ce && gnt_vld) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign xfer      = reset & ce & gnt_vld;
    assign a_sel     = req_a[gnt_idx*A_WIDTH +: A_WIDTH];
    assign b_sel     = req_b[gnt_idx*B_WIDTH +: B_WIDTH];

    // Stage 1: capture the granted operands; insert a bubble when nothing transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_p1_q   <= '0;
            b_p1_q   <= '0;
            tag_p1_q <= '0;
            vld_p1_q <= 1'b0;
        end else if (ce) begin
            vld_p1_q <= xfer;
            if (xfer) begin
                a_p1_q   <= a_sel;
                b_p1_q   <= b_sel;
                tag_p1_q <= gnt_idx;
            end
        end
    end

    // A is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod_full = $signed({1'b0, a_p1_q}) * b_p1_q;

    // Stage 2: multiplier register with tag/valid travelling alongside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_p2_q   <= '0;
            tag_p2_q <= '0;
            vld_p2_q <= 1'b0;
        end else if (ce) begin
            p_p2_q   <= trunc_prod(prod_full);
            tag_p2_q <= tag_p1_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    assign res_valid = vld_p2_q;
    assign res_tag   = tag_p2_q;
    assign res_p     = p_p2_q;
    assign busy      = vld_p1_q | vld_p2_q;

endmodule
